// File: rtl/spi_master_frame.sv
// SPI master that shifts one N-bit frame (MSB first) per accepted start.
// It supports all four CPOL/CPHA modes and a runtime SCLK divider.
module spi_master_frame #(
    parameter int BYTES = 1,
    parameter int NCS   = 1,
    parameter int DIVW  = 8,
    localparam int N    = 8 * BYTES,
    localparam int CSW  = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [CSW-1:0]  cs_sel,
    input  logic [1:0]      mode,
    input  logic [DIVW-1:0] div,
    input  logic [N-1:0]    mdat,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    sdat,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso,
    output logic [NCS-1:0]  cs_n
);

    // state | meaning
    // IDLE  | waiting for start, cs_n high, sclk at CPOL
    // SETUP | cs asserted, one half-period before the first SCLK edge
    // XFER  | 2N SCLK edges, one every H clk cycles
    // HOLD  | one half-period after the last edge before cs release
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int ECW = $clog2(2 * N);

    logic [1:0]      state;
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div_q;
    logic [ECW-1:0]  edge_cnt;
    logic            cpol;
    logic            cpha;
    logic [N-1:0]    tx;
    logic [N-1:0]    rx;
    logic [NCS-1:0]  cs_dec;
    logic            lead_edge;
    logic            sample_edge;
    logic            last_edge;

    // Out-of-range cs_sel decodes to no active line; timing is unaffected.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NCS; i++) begin
            if (int'(cs_sel) == i) cs_dec[i] = 1'b0;
        end
    end

    // Even edge numbers move sclk away from CPOL (leading), odd ones return it.
    assign lead_edge   = ~edge_cnt[0];
    assign sample_edge = lead_edge ^ cpha;
    assign last_edge   = (edge_cnt == ECW'(2 * N - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_q    <= '0;
            edge_cnt <= '0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            tx       <= '0;
            rx       <= '0;
            sdat     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        div_q    <= div;
                        cnt      <= div;
                        edge_cnt <= '0;
                        cpol     <= mode[1];
                        cpha     <= mode[0];
                        sclk     <= mode[1];
                        cs_n     <= cs_dec;
                        // MSB is presented at CS assertion; with CPHA=1 the first
                        // leading edge re-drives it, so tx keeps it for that mode.
                        mosi     <= mdat[N-1];
                        tx       <= mode[0] ? mdat : {mdat[N-2:0], 1'b0};
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= XFER;
                        cnt   <= div_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                XFER: begin
                    if (cnt == '0) begin
                        cnt      <= div_q;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample_edge) begin
                            rx <= {rx[N-2:0], miso};
                        end else if (!last_edge) begin
                            mosi <= tx[N-1];
                            tx   <= {tx[N-2:0], 1'b0};
                        end
                        if (last_edge) state <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cs_n  <= '1;
                        mosi  <= 1'b0;
                        sdat  <= rx;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_frame.sv
// Randomized scoreboard bench for spi_master_frame with a behavioural SPI slave.
// Expected frames are queued at issue time and checked on each done pulse.
module tb_spi_master_frame;

    localparam int BYTES = 2;
    localparam int NCS   = 3;
    localparam int DIVW  = 8;
    localparam int N     = 8 * BYTES;
    localparam int CSW   = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [CSW-1:0]  cs_sel = '0;
    logic [1:0]      mode = '0;
    logic [DIVW-1:0] div = '0;
    logic [N-1:0]    mdat = '0;
    logic            busy;
    logic            done;
    logic [N-1:0]    sdat;
    logic            sclk;
    logic            mosi;
    logic            miso = 1'b0;
    logic [NCS-1:0]  cs_n;

    spi_master_frame #(.BYTES(BYTES), .NCS(NCS), .DIVW(DIVW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cs_sel(cs_sel),
        .mode(mode), .div(div), .mdat(mdat), .busy(busy), .done(done),
        .sdat(sdat), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   sdat;
        logic [N-1:0]   mosi_word;
        logic [NCS-1:0] cs_mask;
        int             cs_low;
        int             latency;
        logic           cpol;
    } exp_t;

    typedef struct {
        logic [1:0]   mode;
        logic [N-1:0] word;
    } slv_t;

    exp_t exp_q[$];
    slv_t slv_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a frame keeps cs low for (2N+2) half-periods and finishes one cycle later.
    function automatic exp_t model(input int c, input logic [1:0] m, input int d,
                                   input logic [N-1:0] md, input logic [N-1:0] w);
        exp_t e;
        int   h;
        h           = d + 1;
        e.sdat      = w;
        e.mosi_word = md;
        e.cpol      = m[1];
        e.latency   = (2 * N + 2) * h + 1;
        if (c < NCS) begin
            e.cs_mask = NCS'(1) << c;
            e.cs_low  = (2 * N + 2) * h;
        end else begin
            e.cs_mask = '0;
            e.cs_low  = 0;
        end
        return e;
    endfunction

    // Behavioural slave: shifts out its word and captures mosi per CPHA.
    slv_t         cur;
    int           sidx;
    logic         lead_pend = 1'b0;
    logic         slv_act = 1'b0;
    logic [N-1:0] cap = '0;

    always @(posedge busy or negedge reset_n) begin
        if (!reset_n) begin
            slv_act = 1'b0;
        end else if (slv_q.size() > 0) begin
            cur       = slv_q.pop_front();
            slv_act   = 1'b1;
            cap       = '0;
            lead_pend = 1'b0;
            if (cur.mode[0] == 1'b0) begin
                sidx = N - 1;
                miso = cur.word[N-1];
            end else begin
                sidx = N;
            end
        end else begin
            slv_act = 1'b0;
        end
    end

    always @(sclk) begin
        if (slv_act && reset_n) begin
            if (sclk != cur.mode[1]) begin
                lead_pend = 1'b1;
                if (cur.mode[0] == 1'b0) begin
                    cap = {cap[N-2:0], mosi};
                end else if (sidx > 0) begin
                    sidx--;
                    miso = cur.word[sidx];
                end
            end else if (lead_pend) begin
                lead_pend = 1'b0;
                if (cur.mode[0] == 1'b1) begin
                    cap = {cap[N-2:0], mosi};
                end else if (sidx > 0) begin
                    sidx--;
                    miso = cur.word[sidx];
                end
            end
        end
    end

    // Monitor: measures cs/sclk activity and pops the scoreboard on each done.
    int             cyc_since_acc = 0;
    int             cs_low_cnt = 0;
    int             edges = 0;
    int             gap = 0;
    logic [NCS-1:0] cs_seen = '0;
    logic           prev_busy = 1'b0;
    logic           prev_sclk = 1'b0;
    logic           prev_done = 1'b0;
    logic           prev_high = 1'b1;
    logic           b2b = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            cyc_since_acc = 0;
            cs_low_cnt    = 0;
            edges         = 0;
            gap           = 0;
            cs_seen       = '0;
            prev_busy     = 1'b0;
            prev_done     = 1'b0;
            prev_high     = 1'b1;
            b2b           = 1'b0;
            if (done) check("done_in_reset", done, 1'b0);
        end else begin
            cyc_since_acc++;
            if (cs_n != '1) begin
                if (prev_high && b2b) begin
                    check("b2b_cs_gap", gap, 1);
                    b2b = 1'b0;
                end
                cs_low_cnt++;
                cs_seen   = cs_seen | ~cs_n;
                gap       = 0;
                prev_high = 1'b0;
            end else begin
                gap++;
                prev_high = 1'b1;
            end
            if (busy && prev_busy && sclk !== prev_sclk) edges++;
            if (done) begin
                check("done_width", prev_done, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("sdat", sdat, e.sdat);
                    check("mosi_word", cap, e.mosi_word);
                    check("cs_lines", cs_seen, e.cs_mask);
                    check("cs_low_cycles", cs_low_cnt, e.cs_low);
                    check("sclk_edges", edges, 2 * N);
                    check("done_latency", cyc_since_acc, e.latency);
                    check("sclk_idle", sclk, e.cpol);
                    check("done_state", {busy, mosi, cs_n}, {2'b00, {NCS{1'b1}}});
                    b2b = start && (e.cs_mask != '0);
                end
                cs_low_cnt = 0;
                edges      = 0;
                cs_seen    = '0;
            end
            if (start && !busy) cyc_since_acc = 0;
            prev_busy = busy;
            prev_done = done;
        end
        prev_sclk = sclk;
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic issue(input int c, input logic [1:0] m, input int d,
                         input logic [N-1:0] md, input logic [N-1:0] w, input bit noise);
        wait_idle();
        cs_sel = CSW'(c);
        mode   = m;
        div    = DIVW'(d);
        mdat   = md;
        start  = 1'b1;
        exp_q.push_back(model(c, m, d, md, w));
        slv_q.push_back('{m, w});
        @(posedge clk);
        #1;
        start = 1'b0;
        if (noise) begin
            repeat (3) begin
                cs_sel = CSW'($urandom);
                mode   = 2'($urandom);
                div    = DIVW'($urandom);
                mdat   = N'($urandom);
                start  = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [N-1:0] w;
        int           cnt;
        int           k;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, sclk, mosi, cs_n}, {4'b0000, {NCS{1'b1}}});
        check("reset_sdat", sdat, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 2'b00, 0, 16'hA5A5, 16'hA5A5, 1'b0);
        issue(1, 2'b11, 3, N'($urandom), 16'h3C3C, 1'b1);
        issue(2, 2'b01, 0, 16'h1234, N'($urandom), 1'b1);
        issue(2, 2'b10, 1, 16'h1234, N'($urandom), 1'b0);
        issue(3, 2'b00, 2, N'($urandom), N'($urandom), 1'b0);

        // start held high across three frames
        wait_idle();
        cs_sel = 2'd1;
        mode   = 2'b10;
        div    = 8'd1;
        mdat   = 16'hC0DE;
        for (int i = 0; i < 3; i++) begin
            w = N'($urandom);
            exp_q.push_back(model(1, 2'b10, 1, 16'hC0DE, w));
            slv_q.push_back('{2'b10, w});
        end
        start = 1'b1;
        cnt = 0;
        k = 0;
        while (cnt < 3 && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
            if (done) cnt++;
        end
        start = 1'b0;
        check("held_start_frames", cnt, 3);

        // reset in the middle of XFER
        issue(0, 2'b00, 1, 16'hFFFF, 16'hFFFF, 1'b0);
        repeat (12) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {busy, done, sclk, mosi, cs_n}, {4'b0000, {NCS{1'b1}}});
        check("abort_sdat", sdat, '0);
        exp_q.delete();
        slv_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        issue(0, 2'b01, 0, 16'h5A5A, 16'h0F0F, 1'b0);

        for (int i = 0; i < 20; i++) begin
            issue($urandom_range(0, 3), 2'($urandom), $urandom_range(0, 3),
                  N'($urandom), N'($urandom), 1'($urandom));
        end

        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        check("all_frames_done", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
